// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-record type used by the
// register-file write-port arbiter (buffers and registered output stage).
package regfile_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted index.
// Owns the rotating pointer; the pointer moves only on a grant with advance high.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] rr_ptr;
   logic             found;
   int               cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(rr_ptr) + k) % N;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   // Reset to N-1 so requester 0 has first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= IDX_W'(N - 1);
      end else if (advance && found) begin
         rr_ptr <= grant_idx;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources.
// Optional build macro WR_ARB_ZERO_DISCARD_EN: writes to register 0 are granted but dropped.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = RF_DATA_W,   // must not exceed RF_DATA_W
   parameter int ADDR_W  = RF_ADDR_W    // must not exceed RF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      regwrite_ctrl,
   output logic [ADDR_W-1:0]         write_register,
   output logic [DATA_W-1:0]         write_data,
   output logic [(2**ADDR_W)-1:0]    reg_pending
);

   localparam int IDX_W = $clog2(NUM_REQ);

   rf_wr_t               buf_q [NUM_REQ];
   rf_wr_t               out_q;
   logic [NUM_REQ-1:0]   buf_valid;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 any_grant;
   logic                 issue_en;
   logic [ADDR_W-1:0]    grant_addr;
   logic [DATA_W-1:0]    grant_data;

   // Handshake: a write transfers on any edge where req_valid[i] && req_ready[i];
   // req_valid may drop without transfer, and a granted buffer may reload in the
   // same cycle it drains, so a winning requester streams one write per cycle.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         buf_valid[i] = buf_q[i].valid;
         req_ready[i] = !flush && (!buf_q[i].valid || grant[i]);
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (buf_valid),
      .advance   (!flush),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign any_grant  = |grant;
   assign grant_addr = buf_q[grant_idx].addr[ADDR_W-1:0];
   assign grant_data = buf_q[grant_idx].data[DATA_W-1:0];

`ifdef WR_ARB_ZERO_DISCARD_EN
   assign issue_en = any_grant && !flush && (grant_addr != '0);
`else
   assign issue_en = any_grant && !flush;
`endif

   // Flush beats both accept and grant; a granted buffer reloads if it accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
               buf_q[i].valid <= 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
               buf_q[i].valid <= 1'b1;
               buf_q[i].addr  <= RF_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
               buf_q[i].data  <= RF_DATA_W'(req_data[i*DATA_W +: DATA_W]);
            end else if (grant[i]) begin
               buf_q[i].valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q.valid <= issue_en;
         if (any_grant) begin
            out_q.addr <= RF_ADDR_W'(grant_addr);
            out_q.data <= RF_DATA_W'(grant_data);
         end
      end
   end

   assign regwrite_ctrl  = out_q.valid;
   assign write_register = out_q.addr[ADDR_W-1:0];
   assign write_data     = out_q.data[DATA_W-1:0];

   always_comb begin
      reg_pending = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (buf_q[i].valid) begin
            reg_pending[buf_q[i].addr[ADDR_W-1:0]] = 1'b1;
         end
      end
      if (out_q.valid) begin
         reg_pending[write_register] = 1'b1;
      end
`ifdef WR_ARB_ZERO_DISCARD_EN
      reg_pending[0] = 1'b0;
`endif
   end

endmodule
